// File: rtl/instr_cache_pkg.sv
// ----------------------------------------------------------------------------
// instr_cache_pkg
// Shared configuration for the instruction cache: line geometry, the fill
// state encoding and a line-alignment helper.
// ----------------------------------------------------------------------------
package instr_cache_pkg;

  localparam int WORD_BITS   = 32;
  localparam int LINE_WORDS  = 8;
  localparam int OFFSET_BITS = 5;
  localparam int LINE_BITS   = LINE_WORDS * WORD_BITS;
  localparam int WSEL_BITS   = $clog2(LINE_WORDS);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } ic_state_e;

  // Clear the byte offset so the address points at the first byte of its line.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// ----------------------------------------------------------------------------
// icache_line_store
// Direct-mapped line storage: data, tag and valid bit per set.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (valid bits only)
//   clear_all       synchronous invalidate of every line
//   we, wr_*        single write port installing a full line
//   rd_index        combinational read port index
//   rd_tag/rd_data/rd_valid  contents of the addressed set
// ----------------------------------------------------------------------------
module icache_line_store
  import instr_cache_pkg::*;
#(
  parameter int SETS     = 32,
  parameter int IDX_BITS = $clog2(SETS),
  parameter int TAG_BITS = 32 - OFFSET_BITS - IDX_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_all,
  input  logic                 we,
  input  logic [IDX_BITS-1:0]  wr_index,
  input  logic [TAG_BITS-1:0]  wr_tag,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic [IDX_BITS-1:0]  rd_index,
  output logic [TAG_BITS-1:0]  rd_tag,
  output logic [LINE_BITS-1:0] rd_data,
  output logic                 rd_valid
);

  logic [LINE_BITS-1:0] data_mem [SETS];
  logic [TAG_BITS-1:0]  tag_mem  [SETS];
  logic [SETS-1:0]      valid_reg;

  // Data and tag are never reset: a cleared valid bit hides stale contents.
  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[wr_index] <= wr_data;
      tag_mem[wr_index]  <= wr_tag;
    end
  end

  // Invalidate wins over a coincident install of the same line.
  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg[gi] <= 1'b0;
        end else if (clear_all) begin
          valid_reg[gi] <= 1'b0;
        end else if (we && (wr_index == IDX_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  // Lookup has to resolve in the fetch cycle, so the read is combinational.
  assign rd_data  = data_mem[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_reg[rd_index];

endmodule

// File: rtl/instr_cache.sv
// ----------------------------------------------------------------------------
// instr_cache
// Direct-mapped instruction cache returning two consecutive words per fetch,
// with a blocking single-line fill from instruction memory.
// Ports:
//   CLK, RESET                  clock, asynchronous active-high reset
//   Instr_address_2IC           fetch byte address
//   Flush                       invalidate all lines / abort a fill
//   Instr1_fIC/Instr1_valid_fIC word at the fetch address and its hit flag
//   Instr2_fIC/Instr2_valid_fIC next word when it lies in the same line
//   Instr_address_2IM, iBlkRead line fill request to memory
//   block_read_fIM(_valid)      returned line (word0 in [31:0])
//   Hit_count, Miss_count       wrapping statistics counters
// ----------------------------------------------------------------------------
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int SETS = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [31:0]          Instr_address_2IC,
  input  logic                 Flush,
  output logic [31:0]          Instr1_fIC,
  output logic [31:0]          Instr2_fIC,
  output logic                 Instr1_valid_fIC,
  output logic                 Instr2_valid_fIC,
  output logic [31:0]          Instr_address_2IM,
  output logic                 iBlkRead,
  input  logic [LINE_BITS-1:0] block_read_fIM,
  input  logic                 block_read_fIM_valid,
  output logic [31:0]          Hit_count,
  output logic [31:0]          Miss_count
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = 32 - OFFSET_BITS - IDX_BITS;

  ic_state_e            state_reg, state_next;
  logic [31:0]          fill_addr_reg, fill_addr_next;
  logic [31:0]          hit_count_reg, hit_count_next;
  logic [31:0]          miss_count_reg, miss_count_next;
  logic                 fill_we;

  logic [IDX_BITS-1:0]  cur_index;
  logic [TAG_BITS-1:0]  cur_tag;
  logic [WSEL_BITS-1:0] word_sel;
  logic [WSEL_BITS-1:0] word_nxt;
  logic [TAG_BITS-1:0]  rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic                 lookup_hit;
  logic                 unused_byte_bits;

  assign cur_index        = Instr_address_2IC[OFFSET_BITS+IDX_BITS-1:OFFSET_BITS];
  assign cur_tag          = Instr_address_2IC[31:OFFSET_BITS+IDX_BITS];
  assign word_sel         = Instr_address_2IC[OFFSET_BITS-1:2];
  assign word_nxt         = word_sel + 1'b1;
  assign unused_byte_bits = ^Instr_address_2IC[1:0];

  icache_line_store #(
    .SETS (SETS)
  ) u_store (
    .clk       (CLK),
    .rst       (RESET),
    .clear_all (Flush),
    .we        (fill_we),
    .wr_index  (fill_addr_reg[OFFSET_BITS+IDX_BITS-1:OFFSET_BITS]),
    .wr_tag    (fill_addr_reg[31:OFFSET_BITS+IDX_BITS]),
    .wr_data   (block_read_fIM),
    .rd_index  (cur_index),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  // Lookups only count while idle; during a fill the fetch stage sees NOPs.
  assign lookup_hit = (state_reg == ST_IDLE) && rd_valid && (rd_tag == cur_tag);

  assign Instr1_valid_fIC = lookup_hit;
  assign Instr1_fIC       = lookup_hit ? rd_data[word_sel*WORD_BITS +: WORD_BITS] : 32'h0;
  // The second word is only offered if it sits in the same line.
  assign Instr2_valid_fIC = lookup_hit && (word_sel != WSEL_BITS'(LINE_WORDS - 1));
  assign Instr2_fIC       = Instr2_valid_fIC ? rd_data[word_nxt*WORD_BITS +: WORD_BITS] : 32'h0;

  // Driven straight from state so an asynchronous reset drops the request at once.
  assign iBlkRead          = (state_reg == ST_FILL);
  assign Instr_address_2IM = (state_reg == ST_FILL) ? fill_addr_reg : 32'h0;

  assign Hit_count  = hit_count_reg;
  assign Miss_count = miss_count_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= ST_IDLE;
      fill_addr_reg  <= 32'h0;
      hit_count_reg  <= 32'h0;
      miss_count_reg <= 32'h0;
    end else begin
      state_reg      <= state_next;
      fill_addr_reg  <= fill_addr_next;
      hit_count_reg  <= hit_count_next;
      miss_count_reg <= miss_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    fill_addr_next  = fill_addr_reg;
    hit_count_next  = hit_count_reg;
    miss_count_next = miss_count_reg;
    fill_we         = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (lookup_hit) begin
          hit_count_next = hit_count_reg + 32'd1;
        end else if (!Flush) begin
          state_next      = ST_FILL;
          fill_addr_next  = line_base(Instr_address_2IC);
          miss_count_next = miss_count_reg + 32'd1;
        end
      end
      ST_FILL: begin
        // Flush aborts the fill; returned data in the same cycle is dropped.
        if (Flush) begin
          state_next = ST_IDLE;
        end else if (block_read_fIM_valid) begin
          fill_we    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 SHALL have parameter SETS, default 32, number of direct-mapped lines (power of two, 2..256).
REQ-002 SHALL have ports: CLK  in  1  sole clock, rising edge.
REQ-003 SHALL have: RESET  in  1  asynchronous, active-high reset.
REQ-004 SHALL have: Instr_address_2IC  in  32  fetch byte address from IF.
REQ-005 SHALL have: Flush  in  1  invalidate all lines; driven with SYS.
REQ-006 SHALL have: Instr1_fIC  out  32  word at Instr_address_2IC.
REQ-007 SHALL have: Instr2_fIC  out  32  word at Instr_address_2IC+4.
REQ-008 SHALL have: Instr1_valid_fIC  out  1  Instr1_fIC is a hit. IF stalls when low.
REQ-009 SHALL have: Instr2_valid_fIC  out  1  Instr2_fIC is a hit in the same line.
REQ-010 SHALL have: Instr_address_2IM  out  32  line-aligned fill address.
REQ-011 SHALL have: iBlkRead  out  1  block read request to IM.
REQ-012 SHALL have: block_read_fIM  in  256  fetched line; word0 in bits [31:0].
REQ-013 SHALL have: block_read_fIM_valid  in  1  fill data valid this cycle.
REQ-014 SHALL have: Hit_count, Miss_count  out  32 each  statistics counters.

Function
REQ-015 SHALL decode the address as offset [4:0] (word [4:2], bits [1:0] ignored), index [4+log2(SETS):5], and tag for the remaining upper bits.
REQ-016 SHALL report a hit combinationally in the same cycle when valid[index]=1 and tag matches; Instr1_fIC = line word [4:2].
REQ-017 SHALL drive Instr2_fIC from word [4:2]+1 with Instr2_valid_fIC=1 only when a hit occurs and word index < 7; otherwise Instr2_fIC=0 and Instr2_valid_fIC=0.
REQ-018 SHALL drive Instr1_fIC=32'h0 (NOP) and Instr1_valid_fIC=0 on a miss or while not in IDLE.
REQ-019 SHALL implement FSM IDLE/FILL: IDLE with miss and Flush=0 -> FILL, latching the line address {addr[31:5],5'b0}.
REQ-020 SHALL, in FILL, assert iBlkRead=1 and hold Instr_address_2IM at the latched address until block_read_fIM_valid=1. Instr_address_2IM=0 in IDLE.
REQ-021 SHALL, on block_read_fIM_valid in FILL, write data, tag and valid for the latched line, return to IDLE, and deassert iBlkRead in the following cycle. The refetch then hits with a 1-cycle penalty beyond memory latency.
REQ-022 SHALL ignore block_read_fIM_valid while in IDLE.
REQ-023 SHALL complete a fill for the latched address even when Instr_address_2IC changes during FILL, then look up the current address.
REQ-024 SHALL, when Flush=1, clear all valid bits at the clock edge; if in FILL, abort to IDLE with no line installed.
REQ-025 SHALL give Flush priority: Flush and block_read_fIM_valid in the same cycle -> no install, state IDLE.
REQ-026 SHALL increment Hit_count once per cycle with a hit in IDLE.
REQ-027 SHALL increment Miss_count once per IDLE->FILL transition.
REQ-028 SHALL let both counters wrap modulo 2^32 (0xFFFFFFFF+1 -> 0), and SHALL leave them unchanged by Flush.

Reset
REQ-029 SHALL, on RESET=1 at any time including mid-fill, immediately set: state IDLE, all valid bits 0, iBlkRead=0, Instr_address_2IM=0, counters 0, Instr1/2_valid_fIC=0, Instr1/2_fIC=0.
REQ-030 SHALL not reset line data or tag storage (valid bits suffice).

Structure
REQ-031 SHALL take LINE_WORDS=8, OFFSET_BITS=5, and FSM state encodings from the shared config include, not local literals.
REQ-032 SHALL place data, tag and valid storage in one sub-module, icache_line_store (1 write port, 1 read port, async valid clear). The FSM and counters SHALL live in instr_cache.

Verification
REQ-033 SHALL cover cold miss: reset, addr 0x00400000, valid after 3 cycles -> iBlkRead 1 for 3 cycles, Instr_address_2IM=0x00400000, Miss_count=1, next cycle hit with word0.
REQ-034 SHALL cover a sequential hit: after REQ-033, addr 0x00400018 -> Instr1=word6, Instr2=word7, both valid. Addr 0x0040001C -> Instr2_valid_fIC=0.
REQ-035 SHALL cover a conflict: with SETS=32, 0x00400000 then 0x00400400 (same index) -> second misses, refetch of the first misses again, Miss_count=3.
REQ-036 SHALL cover Flush during FILL: Flush coincident with block_read_fIM_valid -> state IDLE, same address misses again, Hit_count unchanged.
REQ-037 SHALL cover reset mid-fill: RESET asserted async in FILL -> iBlkRead drops without a clock edge, counters 0, and the first fetch after reset misses.
REQ-038 SHALL cover counter wrap: force Hit_count=0xFFFFFFFF, one hit -> Hit_count=0.
